// File: rtl/micro_core_pkg.sv
// micro_core_pkg: opcodes, FSM states and instruction field widths for micro_core
package micro_core_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_ADDI, OP_LDI, OP_LD, OP_ST, OP_OUT, OP_IN, OP_JZ, OP_HALT
  } op_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_e;
  localparam int OP_W = 4;
  localparam int REG_W = 2;
  localparam int IMM_W = 8;
endpackage

// File: rtl/micro_alu.sv
// micro_alu: combinational ALU for the register/immediate arithmetic ops
module micro_alu import micro_core_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] rhs;
  always_comb begin
    rhs = op == OP_ADDI ? imm : b;
    y = op == OP_ADD || op == OP_ADDI ? a + rhs :
        op == OP_SUB ? a - rhs :
        op == OP_AND ? a & rhs :
        op == OP_OR  ? a | rhs :
        op == OP_XOR ? a ^ rhs :
        op == OP_NOT ? ~rhs :
        op == OP_SHL ? a << 1 :
        op == OP_SHR ? a >> 1 : '0;
  end
endmodule

// File: rtl/micro_core.sv
// micro_core: multi-cycle accumulator-style core with fetch/decode/execute FSM,
// four registers, handshaked memory port and output port latches.
module micro_core import micro_core_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NPORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_done,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NPORTS*DATA_W-1:0] port_out,
  output logic [ADDR_W-1:0]        pc,
  output logic                     halted
);
  state_e state;
  op_e op;
  logic [DATA_W-1:0] ir, imm, alu_y, wb;
  logic [DATA_W-1:0] regs [4];
  logic [REG_W-1:0] rd, rs;
  logic [ADDR_W-1:0] pc_nxt;
  always_comb begin
    op = op_e'(ir[DATA_W-1 -: OP_W]);
    rd = ir[DATA_W-1-OP_W -: REG_W];
    rs = ir[DATA_W-1-OP_W-REG_W -: REG_W];
    imm = DATA_W'(ir[IMM_W-1:0]);
    wb = op == OP_LDI ? imm : op == OP_IN ? in_data : alu_y;
    pc_nxt = op == OP_JZ && regs[rd] == '0 ? imm[ADDR_W-1:0] : pc;
  end
  micro_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op),
    .a  (regs[rd]),
    .b  (regs[rs]),
    .imm(imm),
    .y  (alu_y)
  );
  // Request outputs are registered; the next fetch is issued on the EXEC or MEM-done edge.
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      pc <= '0;
      ir <= '0;
      regs <= '{default: '0};
      port_out <= '0;
      halted <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else
      case (state)
        S_FETCH:
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_addr <= pc;
          end else if (mem_done) begin
            ir <= mem_rdata;
            mem_req <= 1'b0;
            state <= S_DECODE;
          end
        S_DECODE: begin
          pc <= pc + 1'b1;
          if (op == OP_HALT) begin
            state <= S_HALT;
            halted <= 1'b1;
          end else if (op == OP_LD || op == OP_ST) begin
            state <= S_MEM;
            mem_req <= 1'b1;
            mem_we <= op == OP_ST;
            mem_addr <= regs[rs][ADDR_W-1:0];
            mem_wdata <= regs[rd];
          end else
            state <= S_EXEC;
        end
        S_EXEC: begin
          if (op <= OP_LDI || op == OP_IN) regs[rd] <= wb;
          for (int k = 0; k < NPORTS; k++)
            if (op == OP_OUT && imm[1:0] == 2'(k)) port_out[k*DATA_W +: DATA_W] <= regs[rd];
          pc <= pc_nxt;
          mem_req <= 1'b1;
          mem_addr <= pc_nxt;
          state <= S_FETCH;
        end
        S_MEM:
          if (mem_done) begin
            if (!mem_we) regs[rd] <= mem_rdata;
            mem_we <= 1'b0;
            mem_addr <= pc;
            state <= S_FETCH;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_micro_core.sv
// tb_micro_core: directed programs checked against an instruction-level model of the core
module tb_micro_core;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_req, mem_we, mem_done, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata, in_data;
  logic [NP*DW-1:0] port_out;
  logic mdone = 1'b0;
  logic inj = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] img [256];
  logic [DW-1:0] mem [256];
  logic [DW-1:0] mm [256];
  int lat = 1;
  int mcnt = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic [7:0] m_pc;
  logic [31:0] m_port;
  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic        fetch;
    logic [31:0] port;
    int          gap;
  } txn_t;
  txn_t q[$];

  assign mem_done = mdone | inj;
  assign mem_rdata = rdata;
  always #5 clk = ~clk;

  micro_core #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .in_data(in_data),
    .port_out(port_out), .pc(pc), .halted(halted)
  );

  // Memory: reloads the program image during reset, answers lat cycles after it sees mem_req.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
      mcnt <= 0;
      mdone <= 1'b0;
    end else if (mdone) begin
      mdone <= 1'b0;
      mcnt <= 0;
    end else if (mem_req) begin
      if (mcnt + 1 >= lat) begin
        mdone <= 1'b1;
        rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else
        mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s,
                                      input logic [7:0] im);
    return {op, d, s, im};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      img[i] = '0;
      mm[i] = '0;
    end
  endtask

  task automatic put(input int a, input logic [15:0] w);
    img[a] = w;
    mm[a] = w;
  endtask

  // Instruction-level interpreter: produces the expected memory transactions in program order,
  // the port state visible when each fetch completes, and the cycle gap between fetches.
  task automatic predict();
    logic [7:0] p, nxt, a;
    logic [15:0] r [4];
    logic [15:0] w, im;
    logic [3:0] op;
    logic [1:0] d, s;
    logic [31:0] po;
    int gap;
    p = 0;
    po = 0;
    gap = 0;
    r = '{default: '0};
    for (int n = 0; n < 64; n++) begin
      w = mm[p];
      q.push_back('{addr: p, we: 1'b0, wdata: 16'h0, fetch: 1'b1, port: po, gap: gap});
      op = w[15:12];
      d = w[11:10];
      s = w[9:8];
      im = {8'h00, w[7:0]};
      a = r[s][7:0];
      nxt = p + 8'd1;
      gap = 4 + (lat - 1);
      if (op == 4'hF) begin
        m_pc = nxt;
        m_port = po;
        break;
      end
      case (op)
        4'h0: r[d] = r[d] + r[s];
        4'h1: r[d] = r[d] - r[s];
        4'h2: r[d] = r[d] & r[s];
        4'h3: r[d] = r[d] | r[s];
        4'h4: r[d] = r[d] ^ r[s];
        4'h5: r[d] = ~r[s];
        4'h6: r[d] = r[d] << 1;
        4'h7: r[d] = r[d] >> 1;
        4'h8: r[d] = r[d] + im;
        4'h9: r[d] = im;
        4'hA: begin
          q.push_back('{addr: a, we: 1'b0, wdata: 16'h0, fetch: 1'b0, port: 32'h0, gap: 0});
          r[d] = mm[a];
          gap = 5 + 2 * (lat - 1);
        end
        4'hB: begin
          q.push_back('{addr: a, we: 1'b1, wdata: r[d], fetch: 1'b0, port: 32'h0, gap: 0});
          mm[a] = r[d];
          gap = 5 + 2 * (lat - 1);
        end
        4'hC: if (int'(im[1:0]) < NP) po[int'(im[1:0]) * 16 +: 16] = r[d];
        4'hD: r[d] = in_data;
        4'hE: if (r[d] == 16'h0) nxt = w[7:0];
        default: ;
      endcase
      p = nxt;
    end
  endtask

  // Per-cycle compare against the model: handshake hold, transaction order/content, timing.
  logic prev_req = 1'b0, prev_done = 1'b0, prev_we = 1'b0;
  logic [7:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;
  int last_fetch = 0;
  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (rst || !chk_en)
      prev_req = 1'b0;
    else begin
      if (prev_req && !prev_done)
        chk("hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, prev_we, prev_addr, prev_wdata});
      if (halted) chk("halt_noreq", mem_req, 1'b0);
      if (mem_req && mem_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL txn: got access at %h, expected none", mem_addr);
        end else begin
          t = q.pop_front();
          chk("txn_addr", mem_addr, t.addr);
          chk("txn_we", mem_we, t.we);
          if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
          if (t.fetch) begin
            chk("fetch_pc", pc, t.addr);
            chk("fetch_port", port_out, t.port);
            if (t.gap != 0) chk("fetch_gap", cyc - last_fetch, t.gap);
            last_fetch = cyc;
          end
        end
      end
      prev_req = mem_req;
      prev_done = mem_done;
      prev_we = mem_we;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  // Leaves the bench inside cycle C0, the first cycle with rst low.
  task automatic start(input int l, input logic [15:0] iv);
    chk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lat = l;
    in_data = iv;
    q.delete();
    predict();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic finish_run(input string name);
    int n;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halted"}, halted, 1'b1);
    @(negedge clk);
    chk({name, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int bad, n;
    in_data = '0;
    clear_mem();
    // T1: LDI/LDI/ADD/OUT with 1-cycle memory, exact cycle pins
    put(0, enc(4'h9, 2'd0, 2'd0, 8'h05));
    put(1, enc(4'h9, 2'd1, 2'd0, 8'h03));
    put(2, enc(4'h0, 2'd0, 2'd1, 8'h00));
    put(3, enc(4'hC, 2'd0, 2'd0, 8'h00));
    put(4, enc(4'hF, 2'd0, 2'd0, 8'h00));
    start(1, 16'h0);
    chk("t1_model_port", m_port, 32'h0000_0008);
    @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_port", port_out, 32'h0);
    chk("rst_halted", halted, 1'b0);
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk("t1_port_c17", port_out[15:0], 16'h0008);
    chk("t1_pc_c17", pc, 8'h04);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_halted_c19", halted, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_halted_c20", halted, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) bad++;
    end
    chk("t1_halt_quiet", bad, 0);
    finish_run("t1");
    // T2: SUB wrap, SHR, OUT to a nonexistent port
    clear_mem();
    put(0, enc(4'h9, 2'd0, 2'd0, 8'h00));
    put(1, enc(4'h9, 2'd1, 2'd0, 8'h01));
    put(2, enc(4'h1, 2'd0, 2'd1, 8'h00));
    put(3, enc(4'hC, 2'd0, 2'd0, 8'h00));
    put(4, enc(4'h7, 2'd0, 2'd0, 8'h00));
    put(5, enc(4'hC, 2'd0, 2'd0, 8'h01));
    put(6, enc(4'hC, 2'd1, 2'd0, 8'h03));
    put(7, enc(4'hF, 2'd0, 2'd0, 8'h00));
    start(1, 16'h0);
    chk("t2_model_port", m_port, 32'h7FFF_FFFF);
    finish_run("t2");
    chk("t2_port", port_out, 32'h7FFF_FFFF);
    // T3: ST then LD through r3=0x40 with 3-cycle memory
    clear_mem();
    put(0, enc(4'h9, 2'd2, 2'd0, 8'hAA));
    put(1, enc(4'h9, 2'd3, 2'd0, 8'h40));
    put(2, enc(4'hB, 2'd2, 2'd3, 8'h00));
    put(3, enc(4'hA, 2'd1, 2'd3, 8'h00));
    put(4, enc(4'hC, 2'd1, 2'd0, 8'h01));
    put(5, enc(4'hF, 2'd0, 2'd0, 8'h00));
    start(3, 16'h0);
    chk("t3_model_port", m_port, 32'h00AA_0000);
    finish_run("t3");
    chk("t3_mem40", mem[8'h40], 16'h00AA);
    chk("t3_port1", port_out[31:16], 16'h00AA);
    // T4: JZ taken / not taken and PC wrap 0xFF -> 0x00
    clear_mem();
    put(8'h00, enc(4'hE, 2'd2, 2'd0, 8'h10));
    put(8'h01, enc(4'hC, 2'd2, 2'd0, 8'h00));
    put(8'h02, enc(4'hF, 2'd0, 2'd0, 8'h00));
    put(8'h10, enc(4'h9, 2'd0, 2'd0, 8'h01));
    put(8'h11, enc(4'hE, 2'd0, 2'd0, 8'h30));
    put(8'h12, enc(4'hE, 2'd1, 2'd0, 8'hFE));
    put(8'hFE, enc(4'h9, 2'd2, 2'd0, 8'h07));
    put(8'hFF, enc(4'h8, 2'd2, 2'd0, 8'h01));
    start(2, 16'h0);
    chk("t4_model_pc", m_pc, 8'h03);
    finish_run("t4");
    chk("t4_port0", port_out[15:0], 16'h0008);
    chk("t4_pc", pc, 8'h03);
    // T5: IN and the remaining logic ops
    clear_mem();
    put(0, enc(4'hD, 2'd0, 2'd0, 8'h00));
    put(1, enc(4'h9, 2'd1, 2'd0, 8'h0F));
    put(2, enc(4'h2, 2'd1, 2'd0, 8'h00));
    put(3, enc(4'h4, 2'd0, 2'd1, 8'h00));
    put(4, enc(4'h5, 2'd2, 2'd0, 8'h00));
    put(5, enc(4'h6, 2'd2, 2'd0, 8'h00));
    put(6, enc(4'hC, 2'd2, 2'd0, 8'h00));
    put(7, enc(4'hC, 2'd0, 2'd0, 8'h01));
    put(8, enc(4'h3, 2'd0, 2'd1, 8'h00));
    put(9, enc(4'hC, 2'd0, 2'd0, 8'h01));
    put(10, enc(4'hF, 2'd0, 2'd0, 8'h00));
    start(1, 16'h1234);
    chk("t5_model_port", m_port, 32'h1234_DB9E);
    finish_run("t5");
    chk("t5_port", port_out, 32'h1234_DB9E);
    // T6: reset in the middle of a 5-cycle LD wait, then a stray mem_done
    clear_mem();
    put(0, enc(4'h9, 2'd1, 2'd0, 8'h20));
    put(1, enc(4'hA, 2'd1, 2'd1, 8'h00));
    put(2, enc(4'hF, 2'd0, 2'd0, 8'h00));
    start(5, 16'h0);
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 8'h20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_ld_seen", {mem_req, mem_addr}, {1'b1, 8'h20});
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    inj = 1'b1;
    @(negedge clk);
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_we", mem_we, 1'b0);
    chk("t6_rst_addr", mem_addr, 8'h00);
    chk("t6_rst_wdata", mem_wdata, 16'h0000);
    chk("t6_rst_pc", pc, 8'h00);
    chk("t6_rst_port", port_out, 32'h0);
    chk("t6_rst_halted", halted, 1'b0);
    @(posedge clk);
    #1 inj = 1'b0;
    @(negedge clk);
    chk("t6_refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
